// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: adder width,
// output slot state encoding, result bundle and an id-width helper.
package adder_sched_pkg;

    // Width of the shared adder datapath.
    localparam int ADD_W = 32;

    // Widest requester id supported (NREQ up to 16).
    localparam int MAX_IDW = 4;

    // Output slot occupancy.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Result held in the output slot.
    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic               carry;
        logic [ADD_W-1:0]   sum;
    } rsp_t;

    // ceil(log2(n)) but never less than one bit, so NREQ=2 still gets a 1-bit id.
    function automatic int clog2_min1(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the priority pointer, wrapping to index 0 when nothing above is pending.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_pick;

    // Split requests into those at/above the pointer; fall back to all when none are.
    always_comb begin
        w_hi = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_hi[j] = i_req[j] & (j >= int'(i_ptr));
        end
        w_pick = (|w_hi) ? w_hi : i_req;
    end

    // Lowest set bit of the chosen set is the winner; the descending loop lets it win last.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_pick[j]) begin
                o_idx = IDW'(j);
            end else begin
                o_idx = o_idx;
            end
        end
    end

    // One-hot grant, suppressed when the consumer side cannot take a result.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NREQ; j++) begin
            o_grant[j] = i_en & o_any & (o_idx == IDW'(j));
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one 32-bit adder among NREQ requesters.
// One grant per cycle, result registered into a single valid/ready slot
// that can drain and reload in the same cycle.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    input  logic              rsp_ready,
    output logic [31:0]       txn_count
);

    slot_state_t     r_state;
    slot_state_t     w_state_nxt;
    rsp_t            r_rsp;
    logic [IDW-1:0]  r_ptr;
    logic [31:0]     r_txn;

    logic            w_can_accept;
    logic            w_arb_en;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_fire;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [W:0]      w_sum33;
    logic            w_unused_id;

    // Slot is free if empty or being drained this cycle; nothing is granted during reset.
    assign rsp_valid    = (r_state == SLOT_FULL);
    assign w_can_accept = ~rsp_valid | rsp_ready;
    assign w_arb_en     = w_can_accept & ~rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready = w_grant;
    assign w_fire    = w_any & w_arb_en;

    // Route the winner's operands to the shared adder.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a = req_a[i*W +: W];
                w_b = req_b[i*W +: W];
            end else begin
                w_a = w_a;
                w_b = w_b;
            end
        end
    end

    // The single shared adder, zero-extended so bit W is the carry out.
    assign w_sum33 = {1'b0, w_a} + {1'b0, w_b};

    // Slot occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: a grant always (re)fills; a drain without a grant empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = SLOT_FULL;
                end else begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (w_fire) begin
                    w_state_nxt = SLOT_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = SLOT_EMPTY;
                end else begin
                    w_state_nxt = SLOT_FULL;
                end
            end
            default: begin
                w_state_nxt = SLOT_EMPTY;
            end
        endcase
    end

    // Result payload: loaded on grant, held otherwise so backpressure keeps it stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp <= '0;
        end else if (w_fire) begin
            r_rsp <= '{id: MAX_IDW'(w_idx), carry: w_sum33[W], sum: w_sum33[W-1:0]};
        end else begin
            r_rsp <= r_rsp;
        end
    end

    // Priority pointer moves just past the winner, only when a grant happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : (w_idx + IDW'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Completed-response counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn <= 32'd0;
        end else if (rsp_valid & rsp_ready) begin
            r_txn <= r_txn + 32'd1;
        end else begin
            r_txn <= r_txn;
        end
    end

    assign rsp_id    = r_rsp.id[IDW-1:0];
    assign rsp_sum   = r_rsp.sum;
    assign rsp_carry = r_rsp.carry;
    assign txn_count = r_txn;

    // Upper id bits are structurally zero for small NREQ; fold them so they count as consumed.
    assign w_unused_id = ^r_rsp.id;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed and randomized self-checking bench for adder_rr_sched (NREQ=4).
module tb_adder_rr_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  op_a [4];
    logic [31:0]  op_b [4];
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_carry;
    logic         rsp_ready;
    logic [31:0]  txn_count;

    int checks = 0;
    int errors = 0;

    // reference model state for the randomized scenario
    int          m_ptr;
    bit          m_full;
    logic [1:0]  m_id;
    logic [32:0] m_res;
    logic [31:0] m_txn;
    int          gcnt [4];

    always #5 clk = ~clk;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    adder_rr_sched #(.NREQ(4), .W(32), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ready (rsp_ready),
        .txn_count (txn_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin op_a[i] = 32'h1; op_b[i] = 32'h1; end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %h exp %h", req_ready, 4'b0000); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
            checks++; if (txn_count !== 32'd0) begin errors++; $display("FAIL reset_txn got %0d exp 0", txn_count); end
        end
        checks++; if ({rsp_id, rsp_carry, rsp_sum} !== 35'd0) begin errors++; $display("FAIL reset_payload got %h/%b/%h exp 0", rsp_id, rsp_carry, rsp_sum); end
    endtask

    task automatic test_single_add();
        rst = 1'b0; req_valid = 4'b0001; op_a[0] = 32'h0000_0005; op_b[0] = 32'h0000_0003; rsp_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %h exp 1", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_vid got %b/%0d exp 1/0", rsp_valid, rsp_id); end
        checks++; if (rsp_sum !== 32'd8 || rsp_carry !== 1'b0) begin errors++; $display("FAIL single_sum got %h/%b exp 8/0", rsp_sum, rsp_carry); end
        checks++; if (txn_count !== 32'd0) begin errors++; $display("FAIL single_txn0 got %0d exp 0", txn_count); end
        step();
        checks++; if (txn_count !== 32'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_txn1 got %0d/%b exp 1/0", txn_count, rsp_valid); end
    endtask

    task automatic test_overflow();
        req_valid = 4'b0100; op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0001;
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready got %h exp 4", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd2 || rsp_sum !== 32'd0 || rsp_carry !== 1'b1) begin errors++; $display("FAIL ovf1 got id %0d sum %h c %b exp 2/0/1", rsp_id, rsp_sum, rsp_carry); end
        op_a[2] = 32'h8000_0000; op_b[2] = 32'h8000_0000; req_valid = 4'b0100;
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_bypass_ready got %h exp 4", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd2 || rsp_sum !== 32'd0 || rsp_carry !== 1'b1) begin errors++; $display("FAIL ovf2 got id %0d sum %h c %b exp 2/0/1", rsp_id, rsp_sum, rsp_carry); end
        checks++; if (txn_count !== 32'd2) begin errors++; $display("FAIL ovf_txn2 got %0d exp 2", txn_count); end
        step();
        checks++; if (txn_count !== 32'd3 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_txn3 got %0d/%b exp 3/0", txn_count, rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_sum [4];
        logic [1:0]  exp_id;
        exp_sum[0] = 32'h11; exp_sum[1] = 32'h22; exp_sum[2] = 32'h33; exp_sum[3] = 32'h44;
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_reset got %b exp 0", rsp_valid); end
        op_a[0] = 32'h10; op_b[0] = 32'h1; op_a[1] = 32'h20; op_b[1] = 32'h2;
        op_a[2] = 32'h30; op_b[2] = 32'h3; op_a[3] = 32'h40; op_b[3] = 32'h4;
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_id = c[1:0];
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== exp_sum[exp_id]) begin
                errors++; $display("FAIL rr_seq%0d got v%b id %0d sum %h exp 1/%0d/%h", c, rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum[exp_id]);
            end
        end
        req_valid = 4'b0000;
        checks++; if (txn_count !== 32'd7) begin errors++; $display("FAIL rr_txn7 got %0d exp 7", txn_count); end
        step();
        checks++; if (txn_count !== 32'd8 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_txn8 got %0d/%b exp 8/0", txn_count, rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; req_valid = 4'b0010; op_a[1] = 32'h1234_5678; op_b[1] = 32'h1111_1111;
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready_empty got %h exp 2", req_ready); end
        step();
        req_valid = 4'b1000; op_a[3] = 32'hDEAD_0000; op_b[3] = 32'h0000_BEEF;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_held%0d got %h exp 0", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h2345_6789 || rsp_carry !== 1'b0) begin
                errors++; $display("FAIL bp_stable%0d got v%b id %0d sum %h c %b exp 1/1/23456789/0", c, rsp_valid, rsp_id, rsp_sum, rsp_carry);
            end
            step();
        end
        rsp_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_bypass_ready got %h exp 8", req_ready); end
        checks++; if (txn_count !== 32'd8) begin errors++; $display("FAIL bp_txn_held got %0d exp 8", txn_count); end
        step();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 32'hDEAD_BEEF || rsp_carry !== 1'b0) begin
            errors++; $display("FAIL bp_reload got v%b id %0d sum %h c %b exp 1/3/deadbeef/0", rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        checks++; if (txn_count !== 32'd9) begin errors++; $display("FAIL bp_txn9 got %0d exp 9", txn_count); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || txn_count !== 32'd0) begin
            errors++; $display("FAIL mr_clear got v%b id %0d txn %0d exp 0/0/0", rsp_valid, rsp_id, txn_count);
        end
        rst = 1'b0; req_valid = 4'b0100; op_a[2] = 32'h7; op_b[2] = 32'h9;
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd2 || rsp_sum !== 32'h10) begin errors++; $display("FAIL mr_pre got id %0d sum %h exp 2/10", rsp_id, rsp_sum); end
        rst = 1'b1; req_valid = 4'b1010;
        op_a[1] = 32'h100; op_b[1] = 32'h1; op_a[3] = 32'h300; op_b[3] = 32'h3;
        settle();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mr_ready_in_rst got %h exp 0", req_ready); end
        step();
        rst = 1'b0;
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_discard got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_ptr0 got %h exp 2", req_ready); end
        rsp_ready = 1'b1;
        step();
        req_valid = 4'b1000;
        checks++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h101) begin errors++; $display("FAIL mr_first got id %0d sum %h exp 1/101", rsp_id, rsp_sum); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd3 || rsp_sum !== 32'h303) begin errors++; $display("FAIL mr_second got id %0d sum %h exp 3/303", rsp_id, rsp_sum); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_random();
        bit          done;
        bit          can;
        int          win;
        int          j;
        logic [3:0]  exp_rdy;
        rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0;
        step();
        rst = 1'b0;
        m_ptr = 0; m_full = 1'b0; m_id = 2'd0; m_res = 33'd0; m_txn = 32'd0;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    req_valid[i] = 1'b1;
                    op_a[i] = $urandom;
                    op_b[i] = ($urandom_range(0, 7) == 0) ? (~op_a[i] + 32'd1) : $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();
            can = !m_full || rsp_ready;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (win < 0 && req_valid[j]) win = j;
            end
            exp_rdy = (can && win >= 0) ? (4'b0001 << win) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %h exp %h", cyc, req_ready, exp_rdy); end
            if (m_full && rsp_ready) m_txn = m_txn + 32'd1;
            if (exp_rdy != 4'b0000) begin
                m_full = 1'b1;
                m_id = 2'(win);
                m_res = {1'b0, op_a[win]} + {1'b0, op_b[win]};
                m_ptr = (win + 1) % 4;
                gcnt[win]++;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
            step();
            if (exp_rdy != 4'b0000) req_valid = req_valid & ~exp_rdy;
            checks++; if (rsp_valid !== m_full) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, rsp_valid, m_full); end
            if (m_full) begin
                checks++; if (rsp_id !== m_id || {rsp_carry, rsp_sum} !== m_res) begin
                    errors++; $display("FAIL rnd_result cyc %0d got id %0d %b/%h exp id %0d %b/%h", cyc, rsp_id, rsp_carry, rsp_sum, m_id, m_res[32], m_res[31:0]);
                end
            end
            checks++; if (txn_count !== m_txn) begin errors++; $display("FAIL rnd_txn cyc %0d got %0d exp %0d", cyc, txn_count, m_txn); end
            done = (gcnt[0] >= 20) && (gcnt[1] >= 20) && (gcnt[2] >= 20) && (gcnt[3] >= 20);
        end
        checks++; if (!done) begin errors++; $display("FAIL rnd_budget got %0d/%0d/%0d/%0d grants exp >=20 each", gcnt[0], gcnt[1], gcnt[2], gcnt[3]); end
        req_valid = 4'b0000; rsp_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
